// File: rtl/ysyx_22041752_trapctl_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_trapctl_pkg
// Shared definitions for the trap/return sequencer:
//   - machine-mode CSR addresses touched by the sequences
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - 3-bit sequencer state encodings TRAP_IDLE .. TRAP_M_EPC
// ----------------------------------------------------------------------------
package ysyx_22041752_trapctl_pkg;

  localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [2:0] {
    TRAP_IDLE     = 3'd0,
    TRAP_T_EPC    = 3'd1,
    TRAP_T_CAUSE  = 3'd2,
    TRAP_T_STATUS = 3'd3,
    TRAP_T_TVEC   = 3'd4,
    TRAP_M_STATUS = 3'd5,
    TRAP_M_EPC    = 3'd6
  } trap_state_e;

endpackage

// File: rtl/ysyx_22041752_trapctl_mstatus_upd.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_trapctl_mstatus_upd
// Combinational mstatus rewrite shared by trap entry and mret.
//   i_old : current mstatus value (CSR file read data)
//   i_ret : 0 = trap entry (MPIE<=MIE, MIE<=0), 1 = mret (MIE<=MPIE, MPIE<=1)
//   o_new : updated mstatus; MPP forced to machine mode in both cases
// ----------------------------------------------------------------------------
module ysyx_22041752_trapctl_mstatus_upd
  import ysyx_22041752_trapctl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_old,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_new
);

  // Field rewrite; all bits not named here pass through unchanged.
  always_comb begin
    o_new = i_old;
    if (i_ret) begin
      o_new[MSTATUS_MIE]  = i_old[MSTATUS_MPIE];
      o_new[MSTATUS_MPIE] = 1'b1;
    end else begin
      o_new[MSTATUS_MPIE] = i_old[MSTATUS_MIE];
      o_new[MSTATUS_MIE]  = 1'b0;
    end
    o_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/ysyx_22041752_trapctl.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_trapctl
// Trap/return sequencer and single write-port arbiter for the M-mode CSR file.
// Pipeline CSR writes pass straight through in IDLE; exceptions, timer
// interrupts and mret take the port for a short multi-cycle sequence that
// updates mepc/mcause/mstatus and then redirects fetch.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   exc_valid/cause/pc  synchronous exception pulse from the pipeline
//   int_pending/int_pc  timer interrupt request and resume PC
//   mret_valid          mret retiring
//   inst_csr_*          pipeline CSR write request, inst_csr_ready = accepted
//   csr_wen/addr/wdata  CSR file write port (addr also selects csr_rdata)
//   csr_rdata           CSR file combinational read data
//   busy                sequence in progress, pipeline stalls
//   flush               kill younger instructions (accept cycle)
//   redirect_valid/pc   fetch redirect pulse and target
//
// Build option: YSYX_22041752_TRAP_VECTORED_EN enables vectored interrupt
// targets when mtvec.MODE == 1; otherwise every trap goes to mtvec base.
// ----------------------------------------------------------------------------
module ysyx_22041752_trapctl
  import ysyx_22041752_trapctl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INT_CODE = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            int_pending,
  input  logic [XLEN-1:0] int_pc,
  input  logic            mret_valid,
  input  logic            inst_csr_wen,
  input  logic [11:0]     inst_csr_addr,
  input  logic [XLEN-1:0] inst_csr_wdata,
  output logic            inst_csr_ready,
  output logic            csr_wen,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            busy,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] INT_CAUSE = {1'b1, (XLEN-1)'(INT_CODE)};

  trap_state_e     r_state;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
`ifdef YSYX_22041752_TRAP_VECTORED_EN
  logic            r_is_int;
`endif

  logic            w_evt;
  logic [XLEN-1:0] w_mstatus_new;
  logic [XLEN-1:0] w_tvec_base;
  logic [XLEN-1:0] w_tvec_pc;

  // Any sequence-starting event in IDLE; gated by reset so nothing escapes
  // while reset is held.
  assign w_evt = reset_n & (exc_valid | int_pending | mret_valid);

  assign w_tvec_base = {csr_rdata[XLEN-1:2], 2'b00};
`ifdef YSYX_22041752_TRAP_VECTORED_EN
  assign w_tvec_pc = (r_is_int && (csr_rdata[1:0] == 2'b01))
                     ? (w_tvec_base + (XLEN'(INT_CODE) << 2))
                     : w_tvec_base;
`else
  assign w_tvec_pc = w_tvec_base;
`endif

  ysyx_22041752_trapctl_mstatus_upd #(
    .XLEN (XLEN)
  ) u_mstatus_upd (
    .i_old (csr_rdata),
    .i_ret (r_state == TRAP_M_STATUS),
    .o_new (w_mstatus_new)
  );

  // Sequencer state and latched trap context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= TRAP_IDLE;
      r_epc    <= '0;
      r_cause  <= '0;
`ifdef YSYX_22041752_TRAP_VECTORED_EN
      r_is_int <= 1'b0;
`endif
    end else begin
      case (r_state)
        TRAP_IDLE: begin
          if (exc_valid) begin
            r_epc    <= exc_pc;
            r_cause  <= exc_cause;
`ifdef YSYX_22041752_TRAP_VECTORED_EN
            r_is_int <= 1'b0;
`endif
            r_state  <= TRAP_T_EPC;
          end else if (int_pending) begin
            r_epc    <= int_pc;
            r_cause  <= INT_CAUSE;
`ifdef YSYX_22041752_TRAP_VECTORED_EN
            r_is_int <= 1'b1;
`endif
            r_state  <= TRAP_T_EPC;
          end else if (mret_valid) begin
            r_state  <= TRAP_M_STATUS;
          end else begin
            r_state  <= TRAP_IDLE;
          end
        end
        TRAP_T_EPC:    r_state <= TRAP_T_CAUSE;
        TRAP_T_CAUSE:  r_state <= TRAP_T_STATUS;
        TRAP_T_STATUS: r_state <= TRAP_T_TVEC;
        TRAP_T_TVEC:   r_state <= TRAP_IDLE;
        TRAP_M_STATUS: r_state <= TRAP_M_EPC;
        TRAP_M_EPC:    r_state <= TRAP_IDLE;
        default:       r_state <= TRAP_IDLE;
      endcase
    end
  end

  // Port mux and handshake outputs. These are combinational because the CSR
  // file reads combinationally and pipeline writes must pass in the same cycle.
  always_comb begin
    inst_csr_ready = 1'b0;
    csr_wen        = 1'b0;
    csr_addr       = 12'h000;
    csr_wdata      = '0;
    busy           = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      TRAP_IDLE: begin
        if (inst_csr_wen) begin
          csr_addr = inst_csr_addr;
        end else begin
          csr_addr = 12'h000;
        end
        if (w_evt) begin
          // Losing pipeline request is dropped; that instruction gets flushed.
          flush = 1'b1;
        end else if (reset_n && inst_csr_wen) begin
          inst_csr_ready = 1'b1;
          csr_wen        = 1'b1;
          csr_wdata      = inst_csr_wdata;
        end else begin
          inst_csr_ready = 1'b0;
        end
      end
      TRAP_T_EPC: begin
        busy      = 1'b1;
        csr_wen   = 1'b1;
        csr_addr  = CSR_ADDR_MEPC;
        csr_wdata = r_epc;
      end
      TRAP_T_CAUSE: begin
        busy      = 1'b1;
        csr_wen   = 1'b1;
        csr_addr  = CSR_ADDR_MCAUSE;
        csr_wdata = r_cause;
      end
      TRAP_T_STATUS: begin
        busy      = 1'b1;
        csr_wen   = 1'b1;
        csr_addr  = CSR_ADDR_MSTATUS;
        csr_wdata = w_mstatus_new;
      end
      TRAP_T_TVEC: begin
        busy           = 1'b1;
        csr_addr       = CSR_ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = w_tvec_pc;
      end
      TRAP_M_STATUS: begin
        busy      = 1'b1;
        csr_wen   = 1'b1;
        csr_addr  = CSR_ADDR_MSTATUS;
        csr_wdata = w_mstatus_new;
      end
      TRAP_M_EPC: begin
        busy           = 1'b1;
        csr_addr       = CSR_ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_trapctl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041752_trapctl
// Directed bench for the trap/return sequencer with a small CSR file model.
// ----------------------------------------------------------------------------
module tb_ysyx_22041752_trapctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_valid;
  logic [63:0] exc_cause;
  logic [63:0] exc_pc;
  logic        int_pending;
  logic [63:0] int_pc;
  logic        mret_valid;
  logic        inst_csr_wen;
  logic [11:0] inst_csr_addr;
  logic [63:0] inst_csr_wdata;
  logic        inst_csr_ready;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        busy;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041752_trapctl #(.XLEN(64), .INT_CODE(7)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .int_pending    (int_pending),
    .int_pc         (int_pc),
    .mret_valid     (mret_valid),
    .inst_csr_wen   (inst_csr_wen),
    .inst_csr_addr  (inst_csr_addr),
    .inst_csr_wdata (inst_csr_wdata),
    .inst_csr_ready (inst_csr_ready),
    .csr_wen        (csr_wen),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .busy           (busy),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // CSR file model: combinational read, write on clock edge.
  logic [63:0] m_mstatus  = 64'h0000_000a_0000_1808;
  logic [63:0] m_mtvec    = 64'h0000_0000_8000_1000;
  logic [63:0] m_mscratch = 64'h0;
  logic [63:0] m_mepc     = 64'h0;
  logic [63:0] m_mcause   = 64'h0;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h340: csr_rdata = m_mscratch;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = 64'h0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen) begin
      case (csr_addr)
        12'h300: m_mstatus  <= csr_wdata;
        12'h305: m_mtvec    <= csr_wdata;
        12'h340: m_mscratch <= csr_wdata;
        12'h341: m_mepc     <= csr_wdata;
        12'h342: m_mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        exc;
    logic [63:0] cause;
    logic [63:0] epc;
    logic        intp;
    logic [63:0] ipc;
    logic        mret;
    logic        iwen;
    logic [11:0] iaddr;
    logic [63:0] iwdata;
    logic        e_ready;
    logic        e_wen;
    logic [11:0] e_addr;
    logic [63:0] e_wdata;
    logic        e_busy;
    logic        e_flush;
    logic        e_rv;
    logic [63:0] e_rpc;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(
    input logic exc, input logic [63:0] cause, input logic [63:0] epc,
    input logic intp, input logic [63:0] ipc, input logic mret,
    input logic iwen, input logic [11:0] iaddr, input logic [63:0] iwdata,
    input logic e_ready, input logic e_wen, input logic [11:0] e_addr,
    input logic [63:0] e_wdata, input logic e_busy, input logic e_flush,
    input logic e_rv, input logic [63:0] e_rpc);
    vec_t v;
    v.exc = exc; v.cause = cause; v.epc = epc; v.intp = intp; v.ipc = ipc;
    v.mret = mret; v.iwen = iwen; v.iaddr = iaddr; v.iwdata = iwdata;
    v.e_ready = e_ready; v.e_wen = e_wen; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_flush = e_flush;
    v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_valid = 1'b0; exc_cause = 64'h0; exc_pc = 64'h0;
    int_pending = 1'b0; int_pc = 64'h0; mret_valid = 1'b0;
    inst_csr_wen = 1'b0; inst_csr_addr = 12'h000; inst_csr_wdata = 64'h0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, {63'h0, inst_csr_ready}, 64'h0);
    chk({nm, "_wen"},   {63'h0, csr_wen}, 64'h0);
    chk({nm, "_addr"},  {52'h0, csr_addr}, 64'h0);
    chk({nm, "_wdata"}, csr_wdata, 64'h0);
    chk({nm, "_busy"},  {63'h0, busy}, 64'h0);
    chk({nm, "_flush"}, {63'h0, flush}, 64'h0);
    chk({nm, "_rv"},    {63'h0, redirect_valid}, 64'h0);
    chk({nm, "_rpc"},   redirect_pc, 64'h0);
  endtask

  // Start a trap from IDLE and measure redirect latency and target.
  task automatic run_trap(input bit is_int, input logic [63:0] exp_rpc, input string nm);
    int n;
    @(posedge clk); #1;
    if (is_int) begin
      int_pending = 1'b1; int_pc = 64'h8000_0300;
    end else begin
      exc_valid = 1'b1; exc_cause = 64'd4; exc_pc = 64'h8000_0080;
    end
    @(negedge clk);
    chk({nm, "_flush"}, {63'h0, flush}, 64'h1);
    @(posedge clk); #1;
    clear_inputs();
    n = 1;
    @(negedge clk);
    while (!redirect_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_rpc"}, redirect_pc, exp_rpc);
  endtask

  initial begin
    logic [63:0] vec_rpc;

    // exc, cause, epc, int, ipc, mret, iwen, iaddr, iwdata,
    //   ready, wen, addr, wdata, busy, flush, rv, rpc
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 0, 12'h000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 12'h340, 64'h55, 1, 1, 12'h340, 64'h55, 0, 0, 0, 0);
    tbl[2]  = mk(1, 64'd2, 64'h8000_0010, 0, 0, 0, 1, 12'h305, 64'h1234,
                 0, 0, 12'h305, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 1, 12'h341, 64'h8000_0010, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 12'h340, 64'h99, 0, 1, 12'h342, 64'd2, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 1, 12'h300, 64'ha_0000_1880, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 0, 12'h305, 0, 1, 0, 1, 64'h8000_1000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 12'h341, 64'h8000_0014,
                 1, 1, 12'h341, 64'h8000_0014, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 12'h000, 0,     0, 0, 12'h000, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 1, 12'h300, 64'ha_0000_1888, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 0, 12'h341, 0, 1, 0, 1, 64'h8000_0014);
    tbl[11] = mk(0, 0, 0, 1, 64'h8000_0200, 1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 1, 12'h341, 64'h8000_0200, 1, 0, 0, 0);
    tbl[13] = mk(1, 64'd5, 64'h123, 0, 0, 0, 0, 12'h000, 0,
                 0, 1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 1, 12'h300, 64'ha_0000_1880, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 0, 12'h305, 0, 1, 0, 1, 64'h8000_1000);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 12'h000, 0,     0, 0, 12'h000, 0, 0, 0, 0, 0);

    clear_inputs();
    reset_n = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      exc_valid = tbl[i].exc; exc_cause = tbl[i].cause; exc_pc = tbl[i].epc;
      int_pending = tbl[i].intp; int_pc = tbl[i].ipc; mret_valid = tbl[i].mret;
      inst_csr_wen = tbl[i].iwen; inst_csr_addr = tbl[i].iaddr;
      inst_csr_wdata = tbl[i].iwdata;
      @(negedge clk);
      chk($sformatf("r%0d_ready", i), {63'h0, inst_csr_ready}, {63'h0, tbl[i].e_ready});
      chk($sformatf("r%0d_wen", i),   {63'h0, csr_wen}, {63'h0, tbl[i].e_wen});
      chk($sformatf("r%0d_addr", i),  {52'h0, csr_addr}, {52'h0, tbl[i].e_addr});
      chk($sformatf("r%0d_wdata", i), csr_wdata, tbl[i].e_wdata);
      chk($sformatf("r%0d_busy", i),  {63'h0, busy}, {63'h0, tbl[i].e_busy});
      chk($sformatf("r%0d_flush", i), {63'h0, flush}, {63'h0, tbl[i].e_flush});
      chk($sformatf("r%0d_rv", i),    {63'h0, redirect_valid}, {63'h0, tbl[i].e_rv});
      chk($sformatf("r%0d_rpc", i),   redirect_pc, tbl[i].e_rpc);
    end
    clear_inputs();

    chk("csr_mtvec_kept",  m_mtvec, 64'h8000_1000);
    chk("csr_mscratch",    m_mscratch, 64'h55);
    chk("csr_mepc_int",    m_mepc, 64'h8000_0200);
    chk("csr_mcause_int",  m_mcause, 64'h8000_0000_0000_0007);
    chk("csr_mstatus_int", m_mstatus, 64'ha_0000_1880);

    // Reset asserted in T_CAUSE aborts the sequence before mcause/mstatus.
    @(posedge clk); #1;
    exc_valid = 1'b1; exc_cause = 64'd11; exc_pc = 64'h8000_0040;
    @(negedge clk);
    chk("rst_seq_flush", {63'h0, flush}, 64'h1);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_in_cause", {52'h0, csr_addr}, 64'h342);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mepc_written",  m_mepc, 64'h8000_0040);
    chk("rst_mcause_kept",   m_mcause, 64'h8000_0000_0000_0007);
    chk("rst_mstatus_kept",  m_mstatus, 64'ha_0000_1880);
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_after");
    @(posedge clk); #1;
    chk("rst_mcause_still",  m_mcause, 64'h8000_0000_0000_0007);
    inst_csr_wen = 1'b1; inst_csr_addr = 12'h305; inst_csr_wdata = 64'h8000_1001;
    @(negedge clk);
    chk("post_rst_ready", {63'h0, inst_csr_ready}, 64'h1);
    chk("post_rst_wen",   {63'h0, csr_wen}, 64'h1);
    @(posedge clk); #1;
    clear_inputs();
    chk("mtvec_vectored", m_mtvec, 64'h8000_1001);

`ifdef YSYX_22041752_TRAP_VECTORED_EN
    vec_rpc = 64'h8000_101C;
`else
    vec_rpc = 64'h8000_1000;
`endif
    run_trap(1'b1, vec_rpc, "vec_int");
    chk("vec_int_mcause", m_mcause, 64'h8000_0000_0000_0007);
    run_trap(1'b0, 64'h8000_1000, "vec_exc");
    chk("vec_exc_mcause", m_mcause, 64'd4);
    chk("vec_exc_mepc",   m_mepc, 64'h8000_0080);

    @(posedge clk); #1;
    @(negedge clk);
    chk("final_idle_busy", {63'h0, busy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
